// File: rtl/cmd_response_receiver.sv
// Captures a 48-bit SD response from the CMD line: waits for the start bit,
// shifts the frame in MSB-first, checks CRC7 and framing, and enforces NCR timeout.
module cmd_response_receiver #(
  parameter int RESP_WIDTH = 48,
  parameter int TIMEOUT    = 64
) (
  input  logic                  iClock_SD,
  input  logic                  iReset,
  input  logic                  iEnable,
  input  logic                  iCrcCheck,
  input  logic                  iSerial,
  output logic [RESP_WIDTH-1:0] oParallel,
  output logic                  oComplete,
  output logic                  oBusy,
  output logic                  oCrcError,
  output logic                  oFrameError,
  output logic                  oTimeout
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [5:0]    LAST_BIT     = 6'(RESP_WIDTH - 1);
  localparam logic [5:0]    CRC_BITS     = 6'(RESP_WIDTH - 8);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    RECEIVE,
    DONE
  } state_t;

  state_t                state;
  logic [RESP_WIDTH-2:0] shift_reg;
  logic [5:0]            bit_cnt;
  logic [6:0]            crc;
  logic [TW-1:0]         timeout_cnt;
  logic                  crc_en;
  logic [RESP_WIDTH-1:0] next_frame;

  // The MSB of the frame never needs storing: once 47 bits are held, the
  // 48th arrives straight from the line on the completing edge.
  assign next_frame = {shift_reg, iSerial};

  function automatic logic [6:0] crc7_next(input logic [6:0] c, input logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  always_ff @(posedge iClock_SD or negedge iReset) begin
    if (!iReset) begin
      state       <= IDLE;
      shift_reg   <= '0;
      bit_cnt     <= '0;
      crc         <= '0;
      timeout_cnt <= '0;
      crc_en      <= 1'b0;
      oParallel   <= '0;
      oComplete   <= 1'b0;
      oBusy       <= 1'b0;
      oCrcError   <= 1'b0;
      oFrameError <= 1'b0;
      oTimeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iEnable) begin
            state       <= WAIT_START;
            oBusy       <= 1'b1;
            oComplete   <= 1'b0;
            oCrcError   <= 1'b0;
            oFrameError <= 1'b0;
            oTimeout    <= 1'b0;
            crc_en      <= iCrcCheck;
            timeout_cnt <= '0;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            crc         <= '0;
          end
        end
        WAIT_START: begin
          if (!iEnable) begin
            state       <= IDLE;
            oBusy       <= 1'b0;
            oComplete   <= 1'b0;
            oCrcError   <= 1'b0;
            oFrameError <= 1'b0;
            oTimeout    <= 1'b0;
          end else if (!iSerial) begin
            state     <= RECEIVE;
            shift_reg <= '0;
            bit_cnt   <= 6'd1;
            crc       <= crc7_next(7'h00, 1'b0);
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
            if (timeout_cnt == TIMEOUT_LAST) begin
              state     <= DONE;
              oBusy     <= 1'b0;
              oComplete <= 1'b1;
              oTimeout  <= 1'b1;
            end
          end
        end
        RECEIVE: begin
          if (!iEnable) begin
            state       <= IDLE;
            oBusy       <= 1'b0;
            oComplete   <= 1'b0;
            oCrcError   <= 1'b0;
            oFrameError <= 1'b0;
            oTimeout    <= 1'b0;
          end else begin
            shift_reg <= next_frame[RESP_WIDTH-2:0];
            bit_cnt   <= bit_cnt + 1'b1;
            if (bit_cnt < CRC_BITS)
              crc <= crc7_next(crc, iSerial);
            // CRC covers only the 40 header bits, so it is final by now.
            if (bit_cnt == LAST_BIT) begin
              state       <= DONE;
              oParallel   <= next_frame;
              oComplete   <= 1'b1;
              oBusy       <= 1'b0;
              oCrcError   <= crc_en && (crc != next_frame[7:1]);
              oFrameError <= next_frame[RESP_WIDTH-2] || !next_frame[0];
            end
          end
        end
        DONE: begin
          if (!iEnable) begin
            state     <= IDLE;
            oComplete <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
